// File: rtl/picomem_dma_pkg.sv
// Shared definitions for the PicoMem DMA copy engine: register map, status bits, FSM encoding.
package picomem_dma_pkg;

  localparam logic [1:0] RegSrc  = 2'd0;
  localparam logic [1:0] RegDst  = 2'd1;
  localparam logic [1:0] RegLen  = 2'd2;
  localparam logic [1:0] RegCtrl = 2'd3;

  localparam int unsigned StatBusy    = 0;
  localparam int unsigned StatDone    = 1;
  localparam int unsigned StatErr     = 2;
  localparam int unsigned StatAborted = 3;

  localparam int unsigned CtrlStart = 0;
  localparam int unsigned CtrlAbort = 1;

  typedef enum logic [2:0] {StIdle, StRead, StGapW, StWrite, StGapR} dma_state_e;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/picomem_dma_cfg.sv
// Config responder and working register file (SRC/DST/LEN) for the DMA copy engine.
module picomem_dma_cfg
  import picomem_dma_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cfg_valid,
  input  logic [31:0]      cfg_addr,
  input  logic [31:0]      cfg_wdata,
  input  logic [3:0]       cfg_wstrb,
  output logic             cfg_ready,
  output logic [31:0]      cfg_rdata,
  input  logic             busy,
  input  logic             done,
  input  logic             err,
  input  logic             aborted,
  input  logic             adv,
  output logic [31:0]      src,
  output logic [31:0]      dst,
  output logic [LEN_W-1:0] len,
  output logic             start,
  output logic             abort
);

  logic             ready_q;
  logic [31:0]      rdata_q, src_q, dst_q;
  logic [LEN_W-1:0] len_q;
  logic             acc, wr;
  logic [1:0]       sel;
  logic [31:0]      src_merged, dst_merged, len_merged, status, rd_mux;

  assign sel = cfg_addr[3:2];
  assign acc = cfg_valid && !ready_q;
  assign wr  = acc && (cfg_wstrb != 4'h0);

  assign src_merged = strb_merge(src_q, cfg_wdata, cfg_wstrb);
  assign dst_merged = strb_merge(dst_q, cfg_wdata, cfg_wstrb);
  assign len_merged = strb_merge(32'(len_q), cfg_wdata, cfg_wstrb);

  // CTRL bits live in byte 0, so they only act when that lane is enabled.
  assign start = wr && (sel == RegCtrl) && cfg_wstrb[0] && cfg_wdata[CtrlStart];
  assign abort = wr && (sel == RegCtrl) && cfg_wstrb[0] && cfg_wdata[CtrlAbort];

  always_comb begin
    status              = '0;
    status[StatBusy]    = busy;
    status[StatDone]    = done;
    status[StatErr]     = err;
    status[StatAborted] = aborted;
  end

  always_comb begin
    rd_mux = '0;
    unique case (sel)
      RegSrc:  rd_mux = src_q;
      RegDst:  rd_mux = dst_q;
      RegLen:  rd_mux = 32'(len_q);
      RegCtrl: rd_mux = status;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
    end else begin
      ready_q <= acc;
      if (acc) rdata_q <= rd_mux;
      if (adv) begin
        src_q <= src_q + 32'd4;
        dst_q <= dst_q + 32'd4;
        len_q <= len_q - LEN_W'(1);
      end else if (wr && !busy) begin
        case (sel)
          RegSrc:  src_q <= {src_merged[31:2], 2'b00};
          RegDst:  dst_q <= {dst_merged[31:2], 2'b00};
          RegLen:  len_q <= len_merged[LEN_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign cfg_ready = ready_q;
  assign cfg_rdata = rdata_q;
  assign src       = src_q;
  assign dst       = dst_q;
  assign len       = len_q;

  logic unused_cfg;
  assign unused_cfg = ^{cfg_addr[31:4], cfg_addr[1:0], src_merged[1:0], dst_merged[1:0],
                        len_merged[31:LEN_W]};

endmodule

// File: rtl/picomem_dma_copy.sv
// PicoMem DMA copy engine: word-by-word read/write copy over a PicoMem master port.
// Optional bus-wait timeout enabled by defining PICOMEM_DMA_TIMEOUT_EN.
module picomem_dma_copy
  import picomem_dma_pkg::*;
#(
  parameter int unsigned LEN_W = 16
`ifdef PICOMEM_DMA_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1023
`endif
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cfg_valid,
  input  logic [31:0] cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic [3:0]  cfg_wstrb,
  output logic        cfg_ready,
  output logic [31:0] cfg_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        dma_done
);

  dma_state_e       state_q;
  logic             done_q, err_q, aborted_q, abort_pend_q;
  logic [31:0]      rdata_q, src, dst;
  logic [LEN_W-1:0] len;
  logic             busy, adv, start_req, abort_req, start_go, abort_now, tmo_hit;

  assign busy      = (state_q != StIdle);
  assign adv       = (state_q == StWrite) && mem_ready;
  assign start_go  = start_req && !abort_req;
  assign abort_now = abort_pend_q || abort_req;
  assign dma_done  = done_q;

  picomem_dma_cfg #(
    .LEN_W(LEN_W)
  ) u_cfg (
    .clk      (clk),
    .resetn   (resetn),
    .cfg_valid(cfg_valid),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_wstrb(cfg_wstrb),
    .cfg_ready(cfg_ready),
    .cfg_rdata(cfg_rdata),
    .busy     (busy),
    .done     (done_q),
    .err      (err_q),
    .aborted  (aborted_q),
    .adv      (adv),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .start    (start_req),
    .abort    (abort_req)
  );

`ifdef PICOMEM_DMA_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q;

  // Fires on the edge that would begin the TIMEOUT_CYCLES+1'th waiting cycle.
  assign tmo_hit = mem_valid && !mem_ready && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tmo_q <= '0;
    else if (mem_valid && !mem_ready) tmo_q <= tmo_q + TmoW'(1);
    else tmo_q <= '0;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      mem_valid    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      rdata_q      <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      if (abort_req && busy) abort_pend_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (start_go) begin
            done_q    <= (len == '0);
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
            if (len != '0) begin
              state_q   <= StRead;
              mem_valid <= 1'b1;
              mem_addr  <= src;
              mem_wstrb <= 4'h0;
            end
          end
        end
        StRead: begin
          if (tmo_hit) begin
            state_q      <= StIdle;
            mem_valid    <= 1'b0;
            err_q        <= 1'b1;
            abort_pend_q <= 1'b0;
          end else if (mem_ready) begin
            rdata_q   <= mem_rdata;
            mem_valid <= 1'b0;
            if (abort_now) begin
              state_q      <= StIdle;
              aborted_q    <= 1'b1;
              abort_pend_q <= 1'b0;
            end else begin
              state_q <= StGapW;
            end
          end
        end
        StGapW: begin
          if (abort_now) begin
            state_q      <= StIdle;
            aborted_q    <= 1'b1;
            abort_pend_q <= 1'b0;
          end else begin
            state_q   <= StWrite;
            mem_valid <= 1'b1;
            mem_addr  <= dst;
            mem_wdata <= rdata_q;
            mem_wstrb <= 4'hF;
          end
        end
        StWrite: begin
          if (tmo_hit) begin
            state_q      <= StIdle;
            mem_valid    <= 1'b0;
            mem_wstrb    <= 4'h0;
            err_q        <= 1'b1;
            abort_pend_q <= 1'b0;
          end else if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'h0;
            // The register file decrements LEN on this same edge.
            if (len == LEN_W'(1)) begin
              state_q      <= StIdle;
              done_q       <= 1'b1;
              abort_pend_q <= 1'b0;
            end else begin
              state_q <= StGapR;
            end
          end
        end
        StGapR: begin
          if (abort_now) begin
            state_q      <= StIdle;
            aborted_q    <= 1'b1;
            abort_pend_q <= 1'b0;
          end else begin
            state_q   <= StRead;
            mem_valid <= 1'b1;
            mem_addr  <= src;
            mem_wstrb <= 4'h0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
